// File: rtl/sha256_round_ctrl_if.sv
// Block-feed and digest handshake between the padding logic and the SHA-256 controller.
interface sha256_round_ctrl_if;
   logic         start;
   logic         init;
   logic [511:0] block_i;
   logic         ready;
   logic         busy;
   logic         done;
   logic [255:0] digest_o;

   modport master (output start, init, block_i, input ready, busy, done, digest_o);
   modport slave  (input start, init, block_i, output ready, busy, done, digest_o);
endinterface

// File: rtl/sha256_round_ctrl.sv
// Iterative SHA-256 compression: one round per clock, 64 rounds plus a final
// chaining add per 512-bit block; H0..H7 persist across blocks of a message.
module sha256_round_ctrl (
   input  logic               clk,
   input  logic               rst_n,
   sha256_round_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2
   } state_t;

   localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   localparam logic [31:0] K_ROM [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   // One compression round on the packed working state {a,b,c,d,e,f,g,h}.
   function automatic logic [255:0] round_f(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
      t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   state_t       state_r;
   logic [5:0]   t_r;
   logic [255:0] h_r;
   logic [255:0] work_r;
   logic [31:0]  w_r [0:15];
   logic         ready_r;
   logic         busy_r;
   logic         done_r;

   logic [31:0]  w_new_s;
   logic [255:0] round_s;
   logic [255:0] sum_s;

   // Schedule tail word, next working state and the end-of-block chaining sum.
   always_comb begin
      w_new_s = ssig1(w_r[14]) + w_r[9] + ssig0(w_r[1]) + w_r[0];
      round_s = round_f(work_r, K_ROM[t_r], w_r[0]);
      sum_s   = 256'd0;
      for (int i = 0; i < 8; i++) begin
         sum_s[32*i +: 32] = h_r[32*i +: 32] + work_r[32*i +: 32];
      end
   end

   // Controller FSM with its datapath registers and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         t_r     <= 6'd0;
         h_r     <= IV;
         work_r  <= 256'd0;
         for (int i = 0; i < 16; i++) begin
            w_r[i] <= 32'd0;
         end
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  for (int i = 0; i < 16; i++) begin
                     w_r[i] <= bus.block_i[32*(15-i) +: 32];
                  end
                  if (bus.init) begin
                     h_r    <= IV;
                     work_r <= IV;
                  end else begin
                     work_r <= h_r;
                  end
                  t_r     <= 6'd0;
                  state_r <= ROUND;
                  ready_r <= 1'b0;
                  busy_r  <= 1'b1;
               end
            end
            ROUND: begin
               work_r <= round_s;
               for (int i = 0; i < 15; i++) begin
                  w_r[i] <= w_r[i+1];
               end
               w_r[15] <= w_new_s;
               t_r     <= t_r + 6'd1;
               // Leaving on t=63 keeps the 6-bit counter from wrapping into a 65th round.
               if (t_r == 6'd63) begin
                  state_r <= FINAL;
               end
            end
            FINAL: begin
               h_r     <= sum_s;
               done_r  <= 1'b1;
               ready_r <= 1'b1;
               busy_r  <= 1'b0;
               t_r     <= 6'd0;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               t_r     <= 6'd0;
               ready_r <= 1'b1;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready    = ready_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.digest_o = h_r;

endmodule
